// File: rtl/fft_frame_feeder_if.sv
// Sample stream into the FFT frame feeder and butterfly operand pairs out of it.
// The feeder takes the slave view; the sample source / PE side takes the master view.
interface fft_frame_feeder_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic [2*DATA_W-1:0] a;
  logic [2*DATA_W-1:0] b;
  logic [2:0]          power;
  logic                ab_valid;
  logic                frame_done;

  modport master (
    output din,
    output din_valid,
    input  a,
    input  b,
    input  power,
    input  ab_valid,
    input  frame_done
  );

  modport slave (
    input  din,
    input  din_valid,
    output a,
    output b,
    output power,
    output ab_valid,
    output frame_done
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer feeding first-stage (x[k], x[k+8]) pairs of a 16-point FFT to the PE.
// One bank fills from the serial input while the other is issued, so capture never stalls.
module fft_frame_feeder #(
  parameter int unsigned DATA_W = 16  // must match the PE half-word; only 16 is supported
) (
  input logic              clk,
  input logic              rst,
  fft_frame_feeder_if.slave bus
);

  localparam int unsigned NumSamples = 16;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Two banks, no reset: contents are only read after a full frame has been written.
  logic [DATA_W-1:0] mem [2][NumSamples];

  state_e              state_q, state_d;
  logic [3:0]          wr_cnt_q, wr_cnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [2:0]          idx_q, idx_d;
  logic [2*DATA_W-1:0] a_q, a_d;
  logic [2*DATA_W-1:0] b_q, b_d;
  logic [2:0]          power_q, power_d;
  logic                ab_valid_q, ab_valid_d;
  logic                frame_done_q, frame_done_d;

  logic                capture;
  logic                frame_cmp;
  logic [DATA_W-1:0]   rd_lo;
  logic [DATA_W-1:0]   rd_hi;

  assign capture   = bus.din_valid;
  assign frame_cmp = capture && (wr_cnt_q == 4'hF);

  assign rd_lo = mem[rd_bank_q][{1'b0, idx_q}];
  assign rd_hi = mem[rd_bank_q][{1'b1, idx_q}];

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_bank_q][wr_cnt_q] <= bus.din;
    end
  end

  // Write-side bookkeeping.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (capture) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end
    if (frame_cmp) begin
      wr_bank_d = ~wr_bank_q;
      rd_bank_d = wr_bank_q;
    end
  end

  // Issue FSM: outputs are registered and hold their last value while idle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    power_d      = power_q;
    ab_valid_d   = ab_valid_q;
    frame_done_d = frame_done_q;

    unique case (state_q)
      StIdle: begin
        ab_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        if (frame_cmp) begin
          state_d = StIssue;
          idx_d   = 3'd0;
        end
      end

      StIssue: begin
        a_d          = {rd_lo, {DATA_W{1'b0}}};
        b_d          = {rd_hi, {DATA_W{1'b0}}};
        power_d      = idx_q;
        ab_valid_d   = 1'b1;
        frame_done_d = (idx_q == 3'd7);
        idx_d        = idx_q + 3'd1;
        // A frame completing on the last pair chains straight into the next frame.
        if (idx_q == 3'd7) begin
          state_d = frame_cmp ? StIssue : StIdle;
          idx_d   = 3'd0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_cnt_q     <= 4'd0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      idx_q        <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      power_q      <= 3'd0;
      ab_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      power_q      <= power_d;
      ab_valid_q   <= ab_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.power      = power_q;
  assign bus.ab_valid   = ab_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: a frame model pushes expected pairs with their due cycle,
// and every clock edge either pops and compares a pair or requires the outputs to be idle.
module tb_fft_frame_feeder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_frame_feeder_if #(.DATA_W(16)) bus ();

  fft_frame_feeder #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  power;
    logic        fd;
  } pair_t;

  pair_t       sb[$];
  logic [15:0] model [16];
  int          wcnt;
  int          cyc;
  int          n_asserts;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"}, bus.a, 32'h0);
    chk({tag, "_b"}, bus.b, 32'h0);
    chk({tag, "_power"}, {29'h0, bus.power}, 32'h0);
    chk({tag, "_ab_valid"}, {31'h0, bus.ab_valid}, 32'h0);
    chk({tag, "_frame_done"}, {31'h0, bus.frame_done}, 32'h0);
  endtask

  // One clock edge: update the frame model, then check the outputs 1 time unit later.
  task automatic tick();
    logic  cap;
    pair_t p;
    cap = bus.din_valid;
    @(posedge clk);
    cyc++;
    if (cap && !rst) begin
      model[wcnt] = bus.din;
      wcnt++;
      if (wcnt == 16) begin
        wcnt = 0;
        for (int k = 0; k < 8; k++) begin
          p.due   = cyc + 1 + k;
          p.a     = {model[k], 16'h0000};
          p.b     = {model[k+8], 16'h0000};
          p.power = 3'(k);
          p.fd    = (k == 7);
          sb.push_back(p);
        end
      end
    end
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      p = sb.pop_front();
      chk("ab_valid", {31'h0, bus.ab_valid}, 32'h1);
      chk("a", bus.a, p.a);
      chk("b", bus.b, p.b);
      chk("power", {29'h0, bus.power}, {29'h0, p.power});
      chk("frame_done", {31'h0, bus.frame_done}, {31'h0, p.fd});
    end else begin
      chk("ab_valid_idle", {31'h0, bus.ab_valid}, 32'h0);
      chk("frame_done_idle", {31'h0, bus.frame_done}, 32'h0);
    end
  endtask

  task automatic send(input logic [15:0] d);
    bus.din       = d;
    bus.din_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    bus.din_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && sb.size() > 0; i++) begin
      idle();
    end
    chk("drain_empty", 32'(sb.size()), 32'h0);
    idle();
    idle();
  endtask

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    wcnt          = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.din       = 16'h0;
    bus.din_valid = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, continuous valid.
    for (int j = 0; j < 16; j++) begin
      send(16'(16'h0100 * j));
    end
    drain();

    // Gapped input, alternating negative / small positive samples.
    for (int j = 0; j < 16; j++) begin
      send((j % 2 == 0) ? 16'hFF00 : 16'h0080);
      idle();
    end
    drain();

    // Two back-to-back frames; frame 2 capture overlaps frame 1 issue.
    for (int j = 0; j < 16; j++) begin
      send(16'(16'h1000 + 16'h0011 * j));
    end
    for (int j = 0; j < 16; j++) begin
      send((j == 0) ? 16'h8000 : 16'(16'h2000 + 16'h0101 * j));
    end
    drain();

    // Reset asserted after pair 3 of an issuing frame.
    for (int j = 0; j < 16; j++) begin
      send(16'(16'h0A00 + j));
    end
    bus.din_valid = 1'b0;
    for (int i = 0; i < 12 && sb.size() > 4; i++) begin
      tick();
    end
    chk("pairs_before_reset", 32'(sb.size()), 32'h4);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_issue_reset");
    sb.delete();
    wcnt = 0;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle();
    end
    for (int j = 0; j < 16; j++) begin
      send(16'(16'h0300 + 16'h0021 * j));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Upstream neighbour of the 16-point radix-2 butterfly PE.
- Collects a serial stream of 16 real fixed-point samples into ping-pong frame buffers.
- For each complete frame, issues the 8 first-stage butterfly pairs (x[k], x[k+8]) with twiddle index k to the PE on consecutive cycles.
- Input capture continues without stalls while the previous frame is being issued.

Parameters:
- DATA_W, 16: width of each real input sample, signed 8.8 fixed point. Only 16 is supported; it must equal the PE half-word width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  16  signed real input sample.
- din_valid  in  1  din is sampled at a rising edge while this is high.
- a  out  32  PE operand a = {real[15:0], imag[15:0]}.
- b  out  32  PE operand b, same packing as a.
- power  out  3  twiddle index k for W16^k, range 0..7.
- ab_valid  out  1  a, b and power are valid this cycle (one pair per cycle).
- frame_done  out  1  one-cycle pulse coincident with the last pair (k=7) of a frame.

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs: a=0, b=0, power=0, ab_valid=0, frame_done=0.
  - State: wr_cnt=0, wr_bank=0, state=IDLE, idx=0.
  - Buffer contents are don't-care and need not be cleared.
- Storage:
  - Two banks of 16 x 16-bit entries.
  - Sample j of a frame (j = 0..15, arrival order) is stored at bank[wr_bank][j].
- Capture:
  - Each rising edge with din_valid=1 writes din to bank[wr_bank][wr_cnt], then increments wr_cnt (4-bit, wraps 15->0).
  - Gaps in din_valid are allowed. wr_cnt holds during gaps.
- Frame completion: on the edge that captures sample 15:
  - wr_bank toggles.
  - rd_bank is set to the old wr_bank.
  - state goes to ISSUE with idx=0.
- State machine: IDLE and ISSUE.
  - IDLE: ab_valid=0. Go to ISSUE on frame completion.
  - ISSUE, on each edge with output index idx:
    - a <= {bank[rd_bank][idx], 16'h0000}
    - b <= {bank[rd_bank][idx+8], 16'h0000}
    - power <= idx
    - ab_valid <= 1
    - frame_done <= (idx==7)
    - idx <= idx+1
  - After issuing idx=7: return to IDLE. On the following edge ab_valid <= 0 and frame_done <= 0, unless a new frame completed in the same edge.
- Latency: if sample 15 is captured at edge t, pair k is registered at edge t+1+k. ab_valid is high for exactly the 8 cycles following edges t+1 .. t+8.
- Imaginary part of every operand is 0. Real part is passed bit-exact, with no scaling or sign change.
- Overlap:
  - A frame needs at least 16 capture edges and issue takes 8, so issue of frame n always ends before frame n+1 completes.
  - Capture into wr_bank during ISSUE never touches rd_bank.
- Back-to-back frames: if frame completion coincides with the edge issuing idx=7, the next edge starts the new frame at idx=0. ab_valid stays high continuously.
- Reset mid-frame or mid-issue:
  - The partial frame is discarded.
  - Outputs drop asynchronously.
  - The next frame starts from sample 0 into bank 0.
- Outputs hold their last values while ab_valid=0. Consumers must ignore them.

Test Plan:
- Reset check: assert rst mid-simulation -> a=0, b=0, power=0, ab_valid=0 and frame_done=0 immediately, without waiting for a clock edge.
- Single frame: din=16'h0100*j for j=0..15 with continuous valid. Then:
  - pair k has a=32'h(0100*k)_0000 and b=32'h(0100*(k+8))_0000, with power=k.
  - First pair appears at edge t+1.
  - ab_valid is high for exactly 8 cycles.
  - frame_done is high only with power=7.
- Gapped input: din_valid toggles 1/0 with samples 16'hFF00 (j even) and 16'h0080 (j odd). Then a=32'hFF00_0000 for even k, and b follows the same pattern for k+8. Latency is measured from the 16th valid sample.
- Continuous two frames with distinct values, plus a signed check:
  - Frame 2 capture overlaps frame-1 issue.
  - Frame 1 pairs are unchanged; frame 2 pairs carry frame 2 data.
  - Include a sign-extension check using sample 16'h8000, which must appear as a[31:16]=16'h8000.
- Reset mid-issue: assert rst after pair 3 -> no further pairs are issued. A fresh 16-sample frame then issues pairs from bank 0 with correct data.
